// File: rtl/rx_serial_7e1_if.sv
// Serial-side bundle of the 7E1 receiver: the line in, the decoded character,
// strobe, error flags and debug state out.
interface rx_serial_7e1_if;
    logic       dado_serial;
    logic [6:0] dados_ascii;
    logic       pronto;
    logic       erro_paridade;
    logic       erro_stop;
    logic [3:0] db_estado;

    modport master (
        output dado_serial,
        input  dados_ascii,
        input  pronto,
        input  erro_paridade,
        input  erro_stop,
        input  db_estado
    );

    modport slave (
        input  dado_serial,
        output dados_ascii,
        output pronto,
        output erro_paridade,
        output erro_stop,
        output db_estado
    );
endinterface

// File: rtl/rx_serial_7e1.sv
// 7E1 serial receiver: start, 7 data bits LSB first, even parity, stop.
// Samples mid-bit from a half-bit offset after the start edge.
module rx_serial_7e1 #(
    parameter int CLKS_PER_BIT = 434,
    parameter int N            = 9
) (
    input  logic           clock,
    input  logic           reset,
    rx_serial_7e1_if.slave bus
);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_START  = 4'd1;
    localparam logic [3:0] ST_DATA   = 4'd2;
    localparam logic [3:0] ST_PARITY = 4'd3;
    localparam logic [3:0] ST_STOP   = 4'd4;
    localparam logic [3:0] ST_DONE   = 4'd5;

    localparam logic [N-1:0] HALF_LAST = N'(CLKS_PER_BIT / 2 - 1);
    localparam logic [N-1:0] BIT_LAST  = N'(CLKS_PER_BIT - 1);
    localparam logic [N-1:0] CNT_ONE   = N'(1);

    // Data bits and the parity bit together must have an even number of ones.
    function automatic logic parity_error(input logic [7:0] frame_bits);
        return ^frame_bits;
    endfunction

    logic         sync1_r;
    logic         s_rx_r;
    logic         s_rx_prev_r;
    logic [3:0]   state_r;
    logic [3:0]   state_nxt_s;
    logic [N-1:0] cnt_r;
    logic [3:0]   bit_idx_r;
    logic [7:0]   shift_r;
    logic [6:0]   dados_r;
    logic         pronto_r;
    logic         erro_par_r;
    logic         erro_stop_r;
    logic         start_edge_s;
    logic         half_tick_s;
    logic         bit_tick_s;
    logic         sample_s;
    logic         restart_cnt_s;

    assign start_edge_s = s_rx_prev_r & ~s_rx_r;
    assign half_tick_s  = (cnt_r == HALF_LAST);
    assign bit_tick_s   = (cnt_r == BIT_LAST);

    // Two-flop synchroniser plus one delay flop for falling-edge detection.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_r     <= 1'b1;
            s_rx_r      <= 1'b1;
            s_rx_prev_r <= 1'b1;
        end else begin
            sync1_r     <= bus.dado_serial;
            s_rx_r      <= sync1_r;
            s_rx_prev_r <= s_rx_r;
        end
    end

    // Next-state decode; sample_s marks a full-bit sampling point.
    always_comb begin
        state_nxt_s = state_r;
        sample_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_edge_s) state_nxt_s = ST_START;
                else              state_nxt_s = ST_IDLE;
            end
            ST_START: begin
                if (half_tick_s) state_nxt_s = s_rx_r ? ST_IDLE : ST_DATA;
                else             state_nxt_s = ST_START;
            end
            ST_DATA: begin
                if (bit_tick_s) begin
                    sample_s    = 1'b1;
                    state_nxt_s = (bit_idx_r == 4'd7) ? ST_PARITY : ST_DATA;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_tick_s) begin
                    sample_s    = 1'b1;
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_tick_s) begin
                    sample_s    = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
        restart_cnt_s = (state_nxt_s != state_r) | sample_s;
    end

    // State register and bit-timing counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (restart_cnt_s) cnt_r <= '0;
            else               cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Shift register, bit index and held outputs; outputs load on the stop
    // sample so they are visible during the DONE cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            bit_idx_r   <= 4'd0;
            shift_r     <= 8'd0;
            dados_r     <= 7'd0;
            pronto_r    <= 1'b0;
            erro_par_r  <= 1'b0;
            erro_stop_r <= 1'b0;
        end else begin
            pronto_r <= 1'b0;
            case (state_r)
                ST_IDLE: bit_idx_r <= 4'd0;
                ST_START: begin
                    if (half_tick_s && !s_rx_r) bit_idx_r <= 4'd1;
                    else                        bit_idx_r <= bit_idx_r;
                end
                ST_DATA, ST_PARITY: begin
                    if (bit_tick_s) begin
                        shift_r   <= {s_rx_r, shift_r[7:1]};
                        bit_idx_r <= bit_idx_r + 4'd1;
                    end else begin
                        shift_r   <= shift_r;
                    end
                end
                ST_STOP: begin
                    if (bit_tick_s) begin
                        dados_r     <= shift_r[6:0];
                        erro_par_r  <= parity_error(shift_r);
                        erro_stop_r <= ~s_rx_r;
                        pronto_r    <= 1'b1;
                    end else begin
                        dados_r     <= dados_r;
                    end
                end
                default: bit_idx_r <= bit_idx_r;
            endcase
        end
    end

    assign bus.dados_ascii   = dados_r;
    assign bus.pronto        = pronto_r;
    assign bus.erro_paridade = erro_par_r;
    assign bus.erro_stop     = erro_stop_r;
    assign bus.db_estado     = state_r;

endmodule

// File: doc/rx_serial_7e1.md
# rx_serial_7E1

Serial receiver for 7E1 frames at 115200 baud from a 50 MHz clock. A frame is start (0), 7 data bits LSB first, even parity, stop (1). It sits directly downstream of the 7E1 transmitter on the serial link. It deserialises one frame and presents the ASCII character with a one-cycle `pronto` strobe and parity/stop error flags.

## Interface
- `CLKS_PER_BIT`, 434 — clock cycles per bit (50e6/115200).
- `N`, 9 — width of the bit-timing counter; must satisfy 2^N > CLKS_PER_BIT.
- `clock`  in  1  — system clock; all logic on the rising edge.
- `reset`  in  1  — one clock; reset is synchronous and active-low.
- `dado_serial`  in  1  — asynchronous serial line, idle high.
- `dados_ascii`  out  7  — last received character; held until the next frame completes.
- `pronto`  out  1  — one-cycle pulse when a frame completes.
- `erro_paridade`  out  1  — high when the last frame failed even parity; held like `dados_ascii`.
- `erro_stop`  out  1  — high when the last frame's stop bit sampled 0; held like `dados_ascii`.
- `db_estado`  out  4  — current FSM state code, for debug display.

## Operation
- **Synchroniser:** `dado_serial` passes through two flops to give `s_rx`; a third flop gives `s_rx_prev`. All three flops reset to 1.
- **Start detection:** a start edge is `s_rx_prev==1 && s_rx==0`. A line held low never re-triggers.
- **Bit counter:** one N-bit counter, cleared on every state entry and counting up each cycle.
- **Bit index:** a 4-bit index, 0..9.
- **Shift register:** 8 bits, holding 7 data bits plus parity.
- **FSM states and `db_estado` codes:**
  - IDLE (0): wait for a start edge, then go to START.
  - START (1): when the counter reaches HALF-1 (HALF = CLKS_PER_BIT/2, integer), sample `s_rx`.
    - If 1: false start, go to IDLE with no outputs changed.
    - If 0: go to DATA.
  - DATA (2): every CLKS_PER_BIT cycles, sample `s_rx` and shift it in LSB-first. After the 7th sample, go to PARITY.
  - PARITY (3): after CLKS_PER_BIT cycles, sample the parity bit, then go to STOP.
  - STOP (4): after CLKS_PER_BIT cycles, sample the stop bit, then go to DONE.
  - DONE (5): in this single cycle:
    - load `dados_ascii` with the data bits;
    - set `erro_paridade` = XOR of 7 data bits and the parity bit;
    - set `erro_stop` = NOT stop sample;
    - pulse `pronto` = 1;
    - go to IDLE unconditionally.
- A frame with errors still updates `dados_ascii` and still pulses `pronto`.
- Codes 6–15 are unused. An illegal state goes to IDLE on the next cycle.
- **Reset (low) in any state:**
  - FSM goes to IDLE;
  - counters clear;
  - `dados_ascii` = 0, `pronto` = 0, `erro_paridade` = 0, `erro_stop` = 0, `db_estado` = 0.
  - A frame in progress is discarded with no `pronto`.

## Timing
- Cycle t0 is the first cycle in IDLE where the start edge is seen.
- Sample k (0 = start, 1..7 = data, 8 = parity, 9 = stop) is taken at t0 + HALF + k·CLKS_PER_BIT. With defaults, start is sampled at t0+217 and stop at t0+4123.
- `pronto` is high for exactly one cycle, at t0 + HALF + 9·CLKS_PER_BIT + 1 (t0+4124 with defaults).
- `dados_ascii`, `erro_paridade` and `erro_stop` change in that same cycle and nowhere else, except on reset.
- The pin-to-`s_rx` latency is 2 cycles.
- The FSM re-enters IDLE around mid-stop-bit, so back-to-back frames from the transmitter are received without loss.
- Sampling tolerates at least ±3% baud mismatch.

## Test plan
- **Single frame:** drive 0x41 with parity 0 and stop 1 at 434 cycles/bit -> `dados_ascii`=0x41, `pronto` high exactly 1 cycle at t0+4124, both error flags 0.
- **Parity error:** 0x41 with parity bit 1 -> `dados_ascii`=0x41, `erro_paridade`=1, `erro_stop`=0, `pronto` pulses. Then send 0x07 with parity 1 -> `erro_paridade`=0.
- **Framing error:** 0x55 with stop bit 0, line then held low for 5000 cycles -> `erro_stop`=1 and exactly one `pronto`; no new frame starts until the line goes high and low again.
- **Glitch:** a 100-cycle low pulse on an idle line -> `db_estado` returns to 0 after START, no `pronto`, outputs unchanged.
- **Reset mid-frame:** `reset`=0 for 1 cycle during DATA -> next cycle all outputs are 0 and `db_estado`=0; the following valid 0x30 frame is received correctly.
- **Loopback:** connect the transmitter's `saida_serial` to `dado_serial`; send 0x5A then 0x7F back-to-back -> two `pronto` pulses with 0x5A then 0x7F, no error flags.
